// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM encoding and vector helper for irq_ctrl
package irq_pkg;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } irq_state_t;

    function automatic logic [15:0] irq_vec(input logic [15:0] base,
                                            input logic [15:0] stride,
                                            input logic [2:0]  id);
        return base + stride * {13'd0, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder producing {found, index}
module irq_prio_enc #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan high to low so the lowest set bit is the last assignment.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - IF/IE interrupt controller with fixed priority and valid/ack offer
// Optional macro IRQ_EDGE_DETECT_EN: only rising edges of irq_src set IF.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] IF_ADDR    = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR    = IE_ADDR_DEF,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_data_w,
    input  logic               cpu_do_write,
    output logic [7:0]         data_r,
    output logic               data_active,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               ime,
    output logic               wake,
    output logic               irq_valid,
    output logic [2:0]         irq_id,
    output logic [15:0]        irq_vector,
    input  logic               irq_ack
);

    logic [NUM_IRQ-1:0] if_q, if_next, src_set, pend, sel_mask;
    logic [7:0]         ie_q, ie_next, if_rd;
    irq_state_t         state, state_next;
    logic [2:0]         id_next, win_idx;
    logic [15:0]        vec_next;
    logic               found, wr_if, wr_ie, ack_fire, sel_if, sel_ie;

    assign wr_if    = cpu_do_write && (cpu_addr == IF_ADDR);
    assign wr_ie    = cpu_do_write && (cpu_addr == IE_ADDR);
    assign ack_fire = (state == ST_OFFER) && irq_ack;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] src_q;

    always_ff @(posedge clk) begin
        if (reset) src_q <= '0;
        else       src_q <= irq_src;
    end

    assign src_set = irq_src & ~src_q;
`else
    assign src_set = irq_src;
`endif

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) sel_mask[i] = (irq_id == 3'(i));
    end

    // Source set < ack clear < CPU write.
    always_comb begin
        if_next = if_q | src_set;
        if (ack_fire) if_next = if_next & ~sel_mask;
        if (wr_if)    if_next = cpu_data_w[NUM_IRQ-1:0];
    end

    assign ie_next = wr_ie ? cpu_data_w : ie_q;
    assign pend    = if_q & ie_q[NUM_IRQ-1:0];
    assign wake    = |pend;
    assign sel_if  = |(if_next & sel_mask);
    assign sel_ie  = |(ie_next[NUM_IRQ-1:0] & sel_mask);

    irq_prio_enc #(.N(NUM_IRQ), .IDX_W(3)) u_enc (
        .req   (pend),
        .found (found),
        .index (win_idx)
    );

    always_comb begin
        state_next = state;
        id_next    = irq_id;
        vec_next   = irq_vector;
        case (state)
            ST_IDLE: begin
                if (ime && found) begin
                    state_next = ST_OFFER;
                    id_next    = win_idx;
                    vec_next   = irq_vec(VEC_BASE, 16'(VEC_STRIDE), win_idx);
                end
            end
            ST_OFFER: begin
                // Ack has priority; otherwise withdraw if the offer is no longer deliverable.
                if (irq_ack)                        state_next = ST_IDLE;
                else if (!ime || !sel_if || !sel_ie) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q       <= '0;
            ie_q       <= 8'h00;
            state      <= ST_IDLE;
            irq_id     <= 3'd0;
            irq_vector <= VEC_BASE;
        end else begin
            if_q       <= if_next;
            ie_q       <= ie_next;
            state      <= state_next;
            irq_id     <= id_next;
            irq_vector <= vec_next;
        end
    end

    assign irq_valid = (state == ST_OFFER);

    always_comb begin
        if_rd              = 8'hFF;
        if_rd[NUM_IRQ-1:0] = if_q;
    end

    always_comb begin
        data_r      = 8'hFF;
        data_active = 1'b0;
        if (cpu_addr == IF_ADDR) begin
            data_r      = if_rd;
            data_active = 1'b1;
        end else if (cpu_addr == IE_ADDR) begin
            data_r      = ie_q;
            data_active = 1'b1;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl offers and register access
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_w;
    logic        cpu_do_write;
    logic [7:0]  data_r;
    logic        data_active;
    logic [4:0]  irq_src;
    logic        ime;
    logic        wake;
    logic        irq_valid;
    logic [2:0]  irq_id;
    logic [15:0] irq_vector;
    logic        irq_ack;

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q[$];
    logic        prev_valid = 1'b0;

    irq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_w   (cpu_data_w),
        .cpu_do_write (cpu_do_write),
        .data_r       (data_r),
        .data_active  (data_active),
        .irq_src      (irq_src),
        .ime          (ime),
        .wake         (wake),
        .irq_valid    (irq_valid),
        .irq_id       (irq_id),
        .irq_vector   (irq_vector),
        .irq_ack      (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every new offer must match the oldest expected {id, vector}.
    always @(negedge clk) begin
        if (irq_valid && !prev_valid) begin
            logic [18:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_offer: got id %0d vec %0h expected none", irq_id, irq_vector);
            end else begin
                e = exp_q.pop_front();
                check("offer_id", {29'd0, irq_id}, {29'd0, e[18:16]});
                check("offer_vec", {16'd0, irq_vector}, {16'd0, e[15:0]});
            end
        end
        prev_valid = irq_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr     = a;
        cpu_data_w   = d;
        cpu_do_write = 1'b1;
        tick();
        cpu_do_write = 1'b0;
        cpu_addr     = 16'hC000;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        check(name, {24'd0, data_r}, {24'd0, exp});
        cpu_addr = 16'hC000;
        #1;
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [15:0] vec);
        exp_q.push_back({id, vec});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cpu_addr = 16'hC000; cpu_data_w = 8'h00; cpu_do_write = 1'b0;
        irq_src = 5'b0; ime = 1'b0; irq_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state and reads
        check("rst_valid", {31'd0, irq_valid}, 32'd0);
        check("rst_id", {29'd0, irq_id}, 32'd0);
        check("rst_vec", {16'd0, irq_vector}, 32'h0040);
        check("rst_wake", {31'd0, wake}, 32'd0);
        read_check("rd_if_rst", 16'hFF0F, 8'hE0);
        read_check("rd_ie_rst", 16'hFFFF, 8'h00);
        cpu_addr = 16'hC000; #1;
        check("rd_other", {24'd0, data_r}, 32'hFF);
        check("rd_other_active", {31'd0, data_active}, 32'd0);
        cpu_addr = 16'hFF0F; #1;
        check("rd_if_active", {31'd0, data_active}, 32'd1);
        cpu_addr = 16'hC000;

        // Basic offer, latency and priority
        bus_write(16'hFFFF, 8'h05);
        read_check("rd_ie", 16'hFFFF, 8'h05);
        ime = 1'b1;
        push_exp(3'd0, 16'h0040);
        irq_src = 5'b00101;
        tick();
        irq_src = 5'b0;
        check("lat_n1_valid", {31'd0, irq_valid}, 32'd0);
        read_check("if_after_src", 16'hFF0F, 8'hE5);
        tick();
        check("lat_n2_valid", {31'd0, irq_valid}, 32'd1);
        push_exp(3'd2, 16'h0050);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_valid_low", {31'd0, irq_valid}, 32'd0);
        read_check("if_after_ack", 16'hFF0F, 8'hE4);
        tick();
        check("second_offer_valid", {31'd0, irq_valid}, 32'd1);

        // No preemption by higher priority arrival
        irq_src = 5'b00001;
        tick();
        irq_src = 5'b0;
        tick();
        check("no_preempt_id", {29'd0, irq_id}, 32'd2);
        check("no_preempt_valid", {31'd0, irq_valid}, 32'd1);
        read_check("if_preempt", 16'hFF0F, 8'hE5);
        push_exp(3'd0, 16'h0040);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        read_check("if_after_ack2", 16'hFF0F, 8'hE1);
        tick();

        // Withdraw on ime drop
        ime = 1'b0;
        tick();
        check("withdraw_valid", {31'd0, irq_valid}, 32'd0);
        check("withdraw_wake", {31'd0, wake}, 32'd1);
        read_check("withdraw_if", 16'hFF0F, 8'hE1);
        push_exp(3'd0, 16'h0040);
        ime = 1'b1;
        tick();
        check("reoffer_valid", {31'd0, irq_valid}, 32'd1);

        // Source set, ack and CPU write in the same cycle
        irq_src = 5'b00010;
        irq_ack = 1'b1;
        bus_write(16'hFF0F, 8'h10);
        irq_src = 5'b0;
        irq_ack = 1'b0;
        read_check("if_write_wins", 16'hFF0F, 8'hF0);
        check("collide_valid", {31'd0, irq_valid}, 32'd0);
        check("collide_wake", {31'd0, wake}, 32'd0);
        tick();
        check("collide_valid2", {31'd0, irq_valid}, 32'd0);

        // Held level on channel 3
        bus_write(16'hFFFF, 8'h08);
        push_exp(3'd3, 16'h0058);
        irq_src = 5'b01000;
        repeat (3) tick();
        check("held_valid", {31'd0, irq_valid}, 32'd1);
        check("held_id", {29'd0, irq_id}, 32'd3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        read_check("held_if_ack", 16'hFF0F, 8'hF0);
`ifndef IRQ_EDGE_DETECT_EN
        push_exp(3'd3, 16'h0058);
`endif
        tick();
`ifdef IRQ_EDGE_DETECT_EN
        read_check("held_if_edge", 16'hFF0F, 8'hF0);
`else
        read_check("held_if_level", 16'hFF0F, 8'hF8);
`endif
        repeat (5) tick();
        irq_src = 5'b0;
`ifdef IRQ_EDGE_DETECT_EN
        check("edge_no_second", {31'd0, irq_valid}, 32'd0);
`else
        check("level_second", {31'd0, irq_valid}, 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
`endif
        check("held_end_valid", {31'd0, irq_valid}, 32'd0);
        read_check("held_end_if", 16'hFF0F, 8'hF0);

        // Reset mid-handshake with concurrent ack
        bus_write(16'hFFFF, 8'h01);
        push_exp(3'd0, 16'h0040);
        irq_src = 5'b00001;
        tick();
        irq_src = 5'b0;
        tick();
        check("pre_reset_valid", {31'd0, irq_valid}, 32'd1);
        reset = 1'b1;
        irq_ack = 1'b1;
        tick();
        reset = 1'b0;
        irq_ack = 1'b0;
        check("mid_rst_valid", {31'd0, irq_valid}, 32'd0);
        check("mid_rst_vec", {16'd0, irq_vector}, 32'h0040);
        read_check("mid_rst_if", 16'hFF0F, 8'hE0);
        read_check("mid_rst_ie", 16'hFFFF, 8'h00);

        repeat (3) tick();
        check("pending_offers", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
